// File: rtl/mem_trk_pkg.sv
// rtl/mem_trk_pkg.sv - shared types, constants and helpers for the memory write tracker
package mem_trk_pkg;

  // Capture state machine encoding, visible on the state output
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FROZEN = 2'd2
  } trk_state_t;

  // Width of the saturating drop counter
  localparam int DROP_W = 16;

  // Channel id width; a single channel still needs one bit of id
  function automatic int ch_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mem_access_tracker_if.sv
// rtl/mem_access_tracker_if.sv - trace readout valid/ready port
interface mem_access_tracker_if #(
  parameter int TS_W   = 32,
  parameter int CH_W   = 2,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              out_valid;
  logic              out_ready;
  logic [TS_W-1:0]   out_ts;
  logic [CH_W-1:0]   out_ch;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;

  modport master (
    output out_valid, out_ts, out_ch, out_addr, out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_ts, out_ch, out_addr, out_data,
    output out_ready
  );
endinterface

// File: rtl/mem_trk_fifo.sv
// rtl/mem_trk_fifo.sv - show-ahead trace FIFO with synchronous clear and occupancy count
module mem_trk_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             valid_o,
  output logic             full_o,
  output logic [AW:0]      count_o
);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign valid_o = (count_q != '0);
  assign full_o  = (count_q == FULL_CNT);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A pop frees the slot the same cycle, so push at full is fine when popping
  assign do_pop  = pop_i && valid_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Pointers and occupancy; clear wins over any push or pop
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage array; contents are only meaningful below the count
  always_ff @(posedge Clk) begin
    if (Reset && !clear_i && do_push) mem_q[wr_ptr_q] <= push_data_i;
  end
endmodule

// File: rtl/mem_access_tracker.sv
// rtl/mem_access_tracker.sv - multi-channel RAM write snooper feeding a timestamped trace FIFO (option: MEM_TRK_ADDR_FILTER_EN)
module mem_access_tracker
  import mem_trk_pkg::*;
#(
  parameter  int NUM_CH       = 4,
  parameter  int ADDR_W       = 16,
  parameter  int DATA_W       = 16,
  parameter  int DEPTH        = 64,
  parameter  int TS_W         = 32,
  parameter  int STOP_ON_FULL = 0,
  localparam int CH_W         = ch_width(NUM_CH),
  localparam int CNT_W        = $clog2(DEPTH) + 1
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       arm,
  input  logic                       disarm,
  input  logic                       clear,
  input  logic [NUM_CH-1:0]          ch_we,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
  input  logic [NUM_CH*DATA_W-1:0]   ch_data,
`ifdef MEM_TRK_ADDR_FILTER_EN
  input  logic [ADDR_W-1:0]          flt_lo,
  input  logic [ADDR_W-1:0]          flt_hi,
`endif
  mem_access_tracker_if.master       rd,
  output logic [CNT_W-1:0]           fifo_count,
  output logic [DROP_W-1:0]          drop_cnt,
  output logic [1:0]                 state
);
  localparam int              FW       = TS_W + CH_W + ADDR_W + DATA_W;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  trk_state_t         state_q, state_d;
  logic [TS_W-1:0]    ts_q;
  logic [CH_W-1:0]    rr_q, rr_d;
  logic [DROP_W-1:0]  drop_q, drop_d;

  logic [NUM_CH-1:0]  stg_vld_q, stg_vld_d, stg_load, elig, cap, drop_vec;
  logic [TS_W-1:0]    stg_ts_q   [NUM_CH];
  logic [ADDR_W-1:0]  stg_addr_q [NUM_CH];
  logic [DATA_W-1:0]  stg_data_q [NUM_CH];

  logic               grant_vld;
  logic [CH_W-1:0]    grant_idx;
  logic               fifo_full, fifo_vld, pop;
  logic [FW-1:0]      fifo_head, push_data;
  logic [CNT_W-1:0]   fifo_cnt;

  // Address window check; without the filter every write is eligible
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_CH; i++) begin
`ifdef MEM_TRK_ADDR_FILTER_EN
      elig[i] = (ch_addr[i*ADDR_W +: ADDR_W] >= flt_lo) &&
                (ch_addr[i*ADDR_W +: ADDR_W] <= flt_hi);
`else
      elig[i] = 1'b1;
`endif
    end
  end

  assign cap = (state_q == RUN) ? (ch_we & elig) : '0;
  assign pop = fifo_vld && rd.out_ready;

  // Round-robin grant of one pending stage, starting the search at rr_q
  always_comb begin
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    if (!clear && (!fifo_full || pop)) begin
      for (int k = 0; k < NUM_CH; k++) begin
        idx = (int'(rr_q) + k) % NUM_CH;
        if (!grant_vld && stg_vld_q[idx]) begin
          grant_vld = 1'b1;
          grant_idx = CH_W'(idx);
        end
      end
    end
  end

  // Pointer moves to the channel after the winner so it gets lowest priority next
  always_comb begin
    rr_d = rr_q;
    if (grant_vld) rr_d = (int'(grant_idx) == NUM_CH - 1) ? '0 : grant_idx + 1'b1;
  end

  // A stage accepts a new write when empty or when it is draining this cycle
  always_comb begin
    stg_load  = '0;
    drop_vec  = '0;
    stg_vld_d = stg_vld_q;
    for (int i = 0; i < NUM_CH; i++) begin
      stg_load[i] = !clear && cap[i] &&
                    (!stg_vld_q[i] || (grant_vld && (int'(grant_idx) == i)));
      drop_vec[i] = !clear && cap[i] && !stg_load[i];
      if (clear)
        stg_vld_d[i] = 1'b0;
      else if (stg_load[i])
        stg_vld_d[i] = 1'b1;
      else if (grant_vld && (int'(grant_idx) == i))
        stg_vld_d[i] = 1'b0;
    end
  end

  // Add this cycle's drops into the counter, saturating at all ones
  always_comb begin
    logic [DROP_W:0] drop_sum;
    drop_sum = {1'b0, drop_q};
    for (int i = 0; i < NUM_CH; i++) drop_sum = drop_sum + (DROP_W+1)'(drop_vec[i]);
    if (clear)
      drop_d = '0;
    else if (drop_sum[DROP_W])
      drop_d = '1;
    else
      drop_d = drop_sum[DROP_W-1:0];
  end

  // Capture state machine; disarm has priority over arm
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (arm && !disarm) state_d = RUN;
      RUN: begin
        if (disarm)
          state_d = IDLE;
        else if ((STOP_ON_FULL != 0) && (fifo_cnt == FULL_CNT))
          state_d = FROZEN;
      end
      FROZEN: begin
        if (disarm)
          state_d = IDLE;
        else if (arm)
          state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // Timestamp, arbiter pointer, drop counter and state registers
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= IDLE;
      ts_q    <= '0;
      rr_q    <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      ts_q    <= ts_q + 1'b1;
      rr_q    <= rr_d;
      drop_q  <= drop_d;
    end
  end

  // Per-channel one-deep capture stages, stamped with the cycle of the strobe
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      stg_vld_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        stg_ts_q[i]   <= '0;
        stg_addr_q[i] <= '0;
        stg_data_q[i] <= '0;
      end
    end else begin
      stg_vld_q <= stg_vld_d;
      for (int i = 0; i < NUM_CH; i++) begin
        if (stg_load[i]) begin
          stg_ts_q[i]   <= ts_q;
          stg_addr_q[i] <= ch_addr[i*ADDR_W +: ADDR_W];
          stg_data_q[i] <= ch_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign push_data = {stg_ts_q[grant_idx], grant_idx, stg_addr_q[grant_idx], stg_data_q[grant_idx]};

  mem_trk_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .Clk         (Clk),
    .Reset       (Reset),
    .clear_i     (clear),
    .push_i      (grant_vld),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .valid_o     (fifo_vld),
    .full_o      (fifo_full),
    .count_o     (fifo_cnt)
  );

  // Head fields read as zero when nothing is queued
  assign rd.out_valid = fifo_vld;
  assign {rd.out_ts, rd.out_ch, rd.out_addr, rd.out_data} = fifo_vld ? fifo_head : '0;
  assign fifo_count = fifo_cnt;
  assign drop_cnt   = drop_q;
  assign state      = state_q;
endmodule

// File: tb/tb_mem_access_tracker.sv
// tb/tb_mem_access_tracker.sv - scoreboard bench for mem_access_tracker
module tb_mem_access_tracker;
  typedef struct packed {
    logic [31:0] ts;
    logic [1:0]  ch;
    logic [15:0] addr;
    logic [15:0] data;
  } ent_t;

  logic        Clk = 1'b0;
  logic        Reset, arm, disarm, clear;
  logic [3:0]  ch_we;
  logic [63:0] ch_addr, ch_data;
`ifdef MEM_TRK_ADDR_FILTER_EN
  logic [15:0] flt_lo, flt_hi;
`endif
  logic [6:0]  m_count;
  logic [15:0] m_drop, s_drop;
  logic [1:0]  m_state, s_state;
  logic [2:0]  s_count;
  logic [31:0] cyc;
  int          total = 0;
  int          bad = 0;
  ent_t        mq[$];
  ent_t        sq[$];
  ent_t        m_exp, s_exp;

  always #5 Clk = ~Clk;

  mem_access_tracker_if #(.TS_W(32), .CH_W(2), .ADDR_W(16), .DATA_W(16)) mif ();
  mem_access_tracker_if #(.TS_W(32), .CH_W(2), .ADDR_W(16), .DATA_W(16)) sif ();

  mem_access_tracker #(.NUM_CH(4), .ADDR_W(16), .DATA_W(16), .DEPTH(64), .TS_W(32), .STOP_ON_FULL(0)) dut (
    .Clk(Clk), .Reset(Reset), .arm(arm), .disarm(disarm), .clear(clear),
    .ch_we(ch_we), .ch_addr(ch_addr), .ch_data(ch_data),
`ifdef MEM_TRK_ADDR_FILTER_EN
    .flt_lo(flt_lo), .flt_hi(flt_hi),
`endif
    .rd(mif), .fifo_count(m_count), .drop_cnt(m_drop), .state(m_state)
  );

  mem_access_tracker #(.NUM_CH(4), .ADDR_W(16), .DATA_W(16), .DEPTH(4), .TS_W(32), .STOP_ON_FULL(1)) dut_sf (
    .Clk(Clk), .Reset(Reset), .arm(arm), .disarm(disarm), .clear(clear),
    .ch_we(ch_we), .ch_addr(ch_addr), .ch_data(ch_data),
`ifdef MEM_TRK_ADDR_FILTER_EN
    .flt_lo(flt_lo), .flt_hi(flt_hi),
`endif
    .rd(sif), .fifo_count(s_count), .drop_cnt(s_drop), .state(s_state)
  );

  // Reference timestamp: zero in reset, +1 per cycle afterwards
  always @(posedge Clk) begin
    if (!Reset) cyc <= 32'd0;
    else        cyc <= cyc + 32'd1;
  end

  // Scoreboard for the main instance: every accepted head must match the queue
  always @(negedge Clk) begin
    if (Reset && mif.out_valid && mif.out_ready) begin
      total++;
      if (mq.size() == 0) begin
        bad++;
        $display("FAIL main_pop unexpected entry ch=%0d addr=%h data=%h", mif.out_ch, mif.out_addr, mif.out_data);
      end else begin
        m_exp = mq.pop_front();
        if ({mif.out_ts, mif.out_ch, mif.out_addr, mif.out_data} !== m_exp) begin
          bad++;
          $display("FAIL main_pop got ts=%0d ch=%0d addr=%h data=%h want ts=%0d ch=%0d addr=%h data=%h",
                   mif.out_ts, mif.out_ch, mif.out_addr, mif.out_data, m_exp.ts, m_exp.ch, m_exp.addr, m_exp.data);
        end
      end
    end
  end

  // Scoreboard for the stop-on-full instance
  always @(negedge Clk) begin
    if (Reset && sif.out_valid && sif.out_ready) begin
      total++;
      if (sq.size() == 0) begin
        bad++;
        $display("FAIL sf_pop unexpected entry ch=%0d addr=%h data=%h", sif.out_ch, sif.out_addr, sif.out_data);
      end else begin
        s_exp = sq.pop_front();
        if ({sif.out_ts, sif.out_ch, sif.out_addr, sif.out_data} !== s_exp) begin
          bad++;
          $display("FAIL sf_pop got ts=%0d ch=%0d addr=%h data=%h want ts=%0d ch=%0d addr=%h data=%h",
                   sif.out_ts, sif.out_ch, sif.out_addr, sif.out_data, s_exp.ts, s_exp.ch, s_exp.addr, s_exp.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b0; arm = 1'b0; disarm = 1'b0; clear = 1'b0; ch_we = '0;
    mif.out_ready = 1'b0; sif.out_ready = 1'b0;
    tick(); tick();
    Reset = 1'b1;
    mq.delete(); sq.delete();
  endtask

  task automatic pulse_arm();
    arm = 1'b1; tick(); arm = 1'b0;
  endtask

  task automatic drive_write(input int ch, input logic [15:0] a, input logic [15:0] d, input bit em, input bit es);
    ent_t e;
    ch_we = '0;
    ch_we[ch] = 1'b1;
    ch_addr[ch*16 +: 16] = a;
    ch_data[ch*16 +: 16] = d;
    e.ts = cyc; e.ch = 2'(ch); e.addr = a; e.data = d;
    if (em) mq.push_back(e);
    if (es) sq.push_back(e);
    tick();
    ch_we = '0;
  endtask

  task automatic drain(input bit which_sf, output bit ok);
    int n;
    n = 0;
    if (which_sf) sif.out_ready = 1'b1;
    else          mif.out_ready = 1'b1;
    while (((which_sf ? sq.size() : mq.size()) != 0) && n < 300) begin
      tick();
      n++;
    end
    mif.out_ready = 1'b0;
    sif.out_ready = 1'b0;
    ok = ((which_sf ? sq.size() : mq.size()) == 0);
  endtask

  task automatic test_reset();
    Reset = 1'b0; arm = 1'b0; disarm = 1'b0; clear = 1'b0; ch_we = '0;
    ch_addr = '0; ch_data = '0;
    mif.out_ready = 1'b0; sif.out_ready = 1'b0;
    tick(); tick(); tick();
    total++; if (m_state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", m_state); end
    total++; if (m_count !== 7'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", m_count); end
    total++; if (m_drop !== 16'd0) begin bad++; $display("FAIL reset_drop got=%0d want=0", m_drop); end
    total++; if (mif.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", mif.out_valid); end
    total++;
    if ({mif.out_ts, mif.out_ch, mif.out_addr, mif.out_data} !== 66'd0) begin
      bad++; $display("FAIL reset_head got=%h want=0", {mif.out_ts, mif.out_ch, mif.out_addr, mif.out_data});
    end
    total++; if ({s_state, s_count, s_drop} !== 21'd0) begin bad++; $display("FAIL reset_sf got=%h want=0", {s_state, s_count, s_drop}); end
    Reset = 1'b1;
  endtask

  task automatic test_first_write();
    bit ok;
    do_reset();
    pulse_arm();
    total++; if (m_state !== 2'd1) begin bad++; $display("FAIL arm_state got=%0d want=1", m_state); end
    for (int i = 0; i < 10 && cyc != 32'd5; i++) tick();
    drive_write(2, 16'h0010, 16'hBEEF, 1'b1, 1'b0);
    total++; if (mif.out_valid !== 1'b0) begin bad++; $display("FAIL lat1_valid got=%b want=0", mif.out_valid); end
    tick();
    total++;
    if ({mif.out_valid, mif.out_ch, mif.out_addr, mif.out_data, mif.out_ts} !== {1'b1, 2'd2, 16'h0010, 16'hBEEF, 32'd5}) begin
      bad++;
      $display("FAIL first_head got v=%b ch=%0d addr=%h data=%h ts=%0d want v=1 ch=2 addr=0010 data=beef ts=5",
               mif.out_valid, mif.out_ch, mif.out_addr, mif.out_data, mif.out_ts);
    end
    tick();
    total++;
    if ({mif.out_valid, mif.out_addr, mif.out_data, mif.out_ts} !== {1'b1, 16'h0010, 16'hBEEF, 32'd5}) begin
      bad++; $display("FAIL hold_head got v=%b addr=%h data=%h ts=%0d", mif.out_valid, mif.out_addr, mif.out_data, mif.out_ts);
    end
    drain(1'b0, ok);
    total++; if (!ok) begin bad++; $display("FAIL first_drain got=%0d pending want=0", mq.size()); end
  endtask

  task automatic test_all_channels();
    ent_t e;
    do_reset();
    pulse_arm();
    mif.out_ready = 1'b1;
    ch_we = 4'hF;
    for (int k = 0; k < 4; k++) begin
      ch_addr[k*16 +: 16] = 16'h1000 + 16'(k);
      ch_data[k*16 +: 16] = 16'hA000 + 16'(k);
      e.ts = cyc; e.ch = 2'(k); e.addr = 16'h1000 + 16'(k); e.data = 16'hA000 + 16'(k);
      mq.push_back(e);
    end
    tick();
    ch_we = '0;
    tick();
    for (int k = 0; k < 4; k++) begin
      total++;
      if ({mif.out_valid, mif.out_ch} !== {1'b1, 2'(k)}) begin
        bad++; $display("FAIL rr_order slot=%0d got v=%b ch=%0d want v=1 ch=%0d", k, mif.out_valid, mif.out_ch, k);
      end
      tick();
    end
    mif.out_ready = 1'b0;
    total++; if (mif.out_valid !== 1'b0) begin bad++; $display("FAIL rr_empty got=%b want=0", mif.out_valid); end
    total++; if (m_drop !== 16'd0) begin bad++; $display("FAIL rr_drop got=%0d want=0", m_drop); end
  endtask

  task automatic test_drop();
    bit ok;
    mif.out_ready = 1'b0;
    for (int k = 0; k < 64; k++) drive_write(0, 16'(k), ~16'(k), 1'b1, 1'b0);
    tick(); tick(); tick();
    total++; if (m_count !== 7'd64) begin bad++; $display("FAIL fill_count got=%0d want=64", m_count); end
    total++; if (m_drop !== 16'd0) begin bad++; $display("FAIL fill_drop got=%0d want=0", m_drop); end
    drive_write(1, 16'h0111, 16'h1111, 1'b1, 1'b0);
    drive_write(1, 16'h0222, 16'h2222, 1'b0, 1'b0);
    drive_write(1, 16'h0333, 16'h3333, 1'b0, 1'b0);
    tick(); tick();
    total++; if (m_drop !== 16'd2) begin bad++; $display("FAIL drop_cnt got=%0d want=2", m_drop); end
    total++; if ({m_count, m_state} !== {7'd64, 2'd1}) begin bad++; $display("FAIL full_run got count=%0d state=%0d want 64/1", m_count, m_state); end
    drain(1'b0, ok);
    total++; if (!ok) begin bad++; $display("FAIL drop_drain got=%0d pending want=0", mq.size()); end
    tick();
    total++; if (m_count !== 7'd0) begin bad++; $display("FAIL drop_empty got=%0d want=0", m_count); end
  endtask

  task automatic test_clear();
    for (int k = 0; k < 3; k++) drive_write(3, 16'h3000 + 16'(k), 16'h5A00 + 16'(k), 1'b1, 1'b0);
    tick(); tick(); tick();
    total++; if ({m_count, m_drop} !== {7'd3, 16'd2}) begin bad++; $display("FAIL pre_clear got count=%0d drop=%0d want 3/2", m_count, m_drop); end
    clear = 1'b1;
    ch_we = 4'b0001;
    ch_addr[15:0] = 16'h7777;
    ch_data[15:0] = 16'h8888;
    mif.out_ready = 1'b1;
    tick();
    clear = 1'b0; ch_we = '0; mif.out_ready = 1'b0;
    mq.delete();
    total++;
    if ({m_count, m_drop, mif.out_valid} !== {7'd0, 16'd0, 1'b0}) begin
      bad++; $display("FAIL clear got count=%0d drop=%0d valid=%b want 0/0/0", m_count, m_drop, mif.out_valid);
    end
    tick(); tick(); tick();
    total++; if ({m_count, mif.out_valid} !== {7'd0, 1'b0}) begin bad++; $display("FAIL clear_stage got count=%0d valid=%b want 0/0", m_count, mif.out_valid); end
  endtask

`ifdef MEM_TRK_ADDR_FILTER_EN
  task automatic test_filter();
    bit ok;
    do_reset();
    flt_lo = 16'h0100; flt_hi = 16'h01FF;
    pulse_arm();
    drive_write(0, 16'h00FF, 16'h0001, 1'b0, 1'b0);
    drive_write(0, 16'h0100, 16'h0002, 1'b1, 1'b0);
    drive_write(0, 16'h01FF, 16'h0003, 1'b1, 1'b0);
    drive_write(0, 16'h0200, 16'h0004, 1'b0, 1'b0);
    tick(); tick();
    drain(1'b0, ok);
    total++; if (!ok) begin bad++; $display("FAIL flt_drain got=%0d pending want=0", mq.size()); end
    mif.out_ready = 1'b1;
    tick(); tick(); tick();
    mif.out_ready = 1'b0;
    total++; if ({m_count, m_drop} !== {7'd0, 16'd0}) begin bad++; $display("FAIL flt_window got count=%0d drop=%0d want 0/0", m_count, m_drop); end
    flt_lo = 16'h0200; flt_hi = 16'h0100;
    drive_write(0, 16'h0150, 16'h0005, 1'b0, 1'b0);
    tick(); tick(); tick();
    total++; if ({m_count, mif.out_valid, m_drop} !== {7'd0, 1'b0, 16'd0}) begin bad++; $display("FAIL flt_inverted got count=%0d valid=%b drop=%0d", m_count, mif.out_valid, m_drop); end
    flt_lo = 16'h0000; flt_hi = 16'hFFFF;
  endtask
`endif

  task automatic test_stop_on_full();
    bit ok;
    do_reset();
    pulse_arm();
    for (int k = 0; k < 4; k++) begin
      drive_write(0, 16'h4000 + 16'(k), 16'hC000 + 16'(k), 1'b0, 1'b1);
      tick(); tick(); tick();
    end
    total++; if ({s_state, s_count} !== {2'd2, 3'd4}) begin bad++; $display("FAIL sf_frozen got state=%0d count=%0d want 2/4", s_state, s_count); end
    drive_write(0, 16'h4004, 16'hC004, 1'b0, 1'b0);
    tick(); tick(); tick();
    total++;
    if ({s_state, s_count, s_drop} !== {2'd2, 3'd4, 16'd0}) begin
      bad++; $display("FAIL sf_fifth got state=%0d count=%0d drop=%0d want 2/4/0", s_state, s_count, s_drop);
    end
    drain(1'b1, ok);
    total++; if (!ok) begin bad++; $display("FAIL sf_drain got=%0d pending want=0", sq.size()); end
    tick(); tick();
    total++; if ({sif.out_valid, s_count, s_state} !== {1'b0, 3'd0, 2'd2}) begin bad++; $display("FAIL sf_drained got valid=%b count=%0d state=%0d want 0/0/2", sif.out_valid, s_count, s_state); end
    pulse_arm();
    total++; if (s_state !== 2'd1) begin bad++; $display("FAIL sf_rearm got=%0d want=1", s_state); end
    tick(); tick();
    total++; if (s_state !== 2'd1) begin bad++; $display("FAIL sf_stay_run got=%0d want=1", s_state); end
  endtask

  initial begin
`ifdef MEM_TRK_ADDR_FILTER_EN
    flt_lo = 16'h0000; flt_hi = 16'hFFFF;
`endif
    test_reset();
    test_first_write();
    test_all_channels();
    test_drop();
    test_clear();
`ifdef MEM_TRK_ADDR_FILTER_EN
    test_filter();
`endif
    test_stop_on_full();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_access_tracker.md
Name: mem_access_tracker

Overview:
- Synthesizable, parametrised data-memory write tracker for the multi-core garage CPU.
- Snoops NUM_CH independent RAM write ports (we/address/data per core) and timestamps every write.
- Arbitrates captured writes round-robin into one shared trace FIFO.
- Exposes the FIFO through a valid/ready readout port, with drop accounting and a run/freeze state machine.

Parameters:
- NUM_CH, 4, number of snooped write channels (1..16).
- ADDR_W, 16, address width per channel.
- DATA_W, 16, data width per channel.
- DEPTH, 64, trace FIFO entries (power of 2, ≥2).
- TS_W, 32, timestamp counter width.
- STOP_ON_FULL, 0, 1 = freeze capture when FIFO becomes full; 0 = keep running and drop on overflow.

Ports:
- Clk  in  1  clock.
- Reset  in  1  synchronous, active-low reset.
- arm  in  1  pulse; IDLE/FROZEN→RUN.
- disarm  in  1  pulse; RUN→IDLE.
- clear  in  1  synchronous flush of FIFO, stages, drop_cnt; timestamp and state untouched.
- ch_we  in  NUM_CH  per-channel write strobe.
- ch_addr  in  NUM_CH*ADDR_W  packed addresses, channel i at [i*ADDR_W +: ADDR_W].
- ch_data  in  NUM_CH*DATA_W  packed write data.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer accepts head.
- out_ts  out  TS_W  head timestamp.
- out_ch  out  CH_W  head channel id, CH_W = max(1, $clog2(NUM_CH)).
- out_addr  out  ADDR_W  head address.
- out_data  out  DATA_W  head data.
- fifo_count  out  $clog2(DEPTH)+1  occupancy.
- drop_cnt  out  16  dropped writes, saturating at 16'hFFFF.
- state  out  2  0=IDLE, 1=RUN, 2=FROZEN.

Behaviour:
- Reset (Reset==0 at posedge Clk):
  - All outputs 0; state IDLE; timestamp 0; round-robin pointer 0; all stage registers empty.
- Timestamp:
  - Free-running, +1 every cycle after reset.
  - Wraps modulo 2^TS_W.
  - Value sampled in the same cycle the write strobe is seen.
- Capture:
  - Only in RUN. IDLE and FROZEN ignore ch_we; pending stages still drain.
  - Each channel has a 1-deep stage {ts, addr, data}.
  - A write at cycle t fills stage i at edge t+1 if the stage is empty or is granted in cycle t.
  - Otherwise the write is dropped and drop_cnt increments.
  - Several channels dropping in one cycle add their count, saturating.
- Arbiter:
  - Grants at most one pending stage per cycle, only when the FIFO is not full or a pop occurs the same cycle.
  - Search order is rr_ptr, rr_ptr+1, … mod NUM_CH; then rr_ptr ← grant+1 mod NUM_CH.
  - Minimum latency ch_we→out_valid is 2 cycles.
- FIFO:
  - Show-ahead; out_* = head while out_valid.
  - Pop when out_valid && out_ready.
  - Push and pop in the same cycle are legal at any occupancy, including full; count is unchanged.
  - Pointers wrap modulo DEPTH.
  - out_* are held stable while out_valid && !out_ready.
- FSM:
  - IDLE→RUN on arm.
  - RUN→IDLE on disarm.
  - RUN→FROZEN when STOP_ON_FULL=1 and fifo_count reaches DEPTH.
  - FROZEN→RUN on arm, FROZEN→IDLE on disarm.
  - arm and disarm in the same cycle: disarm wins.
- clear:
  - Has priority over push, pop and capture in that cycle.
  - Next cycle: fifo_count=0, out_valid=0, drop_cnt=0, stages empty.

Optional Feature:
- Macro: MEM_TRK_ADDR_FILTER_EN.
- With the macro defined:
  - Adds inputs flt_lo and flt_hi (ADDR_W each).
  - Writes with address outside [flt_lo, flt_hi] inclusive are ignored: not captured and not counted as drops.
  - flt_lo > flt_hi filters everything.
- Without the macro: no filter ports, and all writes are eligible.

Decomposition:
- Shared package mem_trk_pkg:
  - state enum trk_state_t (IDLE, RUN, FROZEN).
  - DROP_W=16 constant.
  - Function ch_width(n) returning max(1, $clog2(n)).
- Natural sub-module mem_trk_fifo:
  - Parametrised width/depth, show-ahead, synchronous clear.
  - Count output; push and pop in the same cycle allowed at full.

Test Plan:
- Reset, arm, ch_we[2]=1 with addr 16'h0010, data 16'hBEEF at ts=5 → two cycles later out_valid=1, out_ch=2, out_addr=0010, out_data=BEEF, out_ts=5.
- All 4 channels write in one cycle, out_ready=1 → 4 entries in channel order 0,1,2,3 on consecutive cycles; drop_cnt=0.
- Channel 1 writes on 3 consecutive cycles with out_ready=0 and the FIFO already full → 2 writes dropped, drop_cnt=2.
- STOP_ON_FULL=1, DEPTH=4, 5 writes → state=FROZEN after the 4th write, the 5th is not captured, fifo_count=4.
- Then arm and drain → state returns to RUN.
- clear asserted on the same cycle as a write and a pop with fifo_count=3 → next cycle fifo_count=0, drop_cnt=0, out_valid=0.
- MEM_TRK_ADDR_FILTER_EN defined, flt_lo=16'h0100, flt_hi=16'h01FF; writes to 0x00FF, 0x0100, 0x01FF, 0x0200 → only 0x0100 and 0x01FF are captured; drop_cnt=0.
